data_bram_loader: RTL and testbench

//  Upstream feeder of the multi-bank data BRAM read by the memory control unit.

---
 rtl/data_bram_loader_pkg.sv | 26 ++
 rtl/data_bram_loader_bank_addr_counter.sv | 46 ++++
 rtl/data_bram_loader.sv | 106 ++++++++++
 tb/tb_data_bram_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_bram_loader_pkg.sv
// Shared types and helpers for the data BRAM loader and its read-side counterpart.
package data_bram_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int unsigned DEF_WIDTH = 16;
   localparam int unsigned DEF_BANKS = 4;
   localparam int unsigned DEF_DEPTH = 256;

   // Ceiling log2, never below 1 so single-entry dimensions still get a bit.
   function automatic int unsigned log2c(input int unsigned v);
      for (int unsigned r = 1; r < 32; r++) begin
         if ((64'd1 << r) >= 64'(v)) return r;
      end
      return 32;
   endfunction

   function automatic int unsigned capacity(input int unsigned banks, input int unsigned depth);
      return banks * depth;
   endfunction

endpackage

// File: rtl/data_bram_loader_bank_addr_counter.sv
// Round-robin bank/address walker with a saturating element count.
import data_bram_loader_pkg::*;

module bank_addr_counter #(
   parameter int unsigned BANKS  = DEF_BANKS,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned ADDR_W = log2c(DEPTH),
   parameter int unsigned BANK_W = log2c(BANKS),
   parameter int unsigned CNT_W  = log2c(BANKS * DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              inc,
   output logic [BANK_W-1:0] bank_idx,
   output logic [ADDR_W-1:0] addr,
   output logic [CNT_W-1:0]  count,
   output logic              full
);

   localparam int unsigned CAP = capacity(BANKS, DEPTH);

   assign full = (count == CNT_W'(CAP));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_idx <= '0;
         addr     <= '0;
         count    <= '0;
      end else if (clr) begin
         bank_idx <= '0;
         addr     <= '0;
         count    <= '0;
      end else if (inc && !full) begin
         count <= count + CNT_W'(1);
         // Wrap-and-carry replaces i%BANKS / i/BANKS.
         if (bank_idx == BANK_W'(BANKS - 1)) begin
            bank_idx <= '0;
            addr     <= addr + ADDR_W'(1);
         end else begin
            bank_idx <= bank_idx + BANK_W'(1);
         end
      end
   end

endmodule

// File: rtl/data_bram_loader.sv
// Streams AXI-S elements round-robin into a multi-bank data BRAM and flags a complete block.
import data_bram_loader_pkg::*;

module data_bram_loader #(
   parameter int unsigned DATA_WIDTH_DATA = DEF_WIDTH,
   parameter int unsigned DATA_BANKS      = DEF_BANKS,
   parameter int unsigned DATA_BANK_DEPTH = DEF_DEPTH,
   parameter int unsigned DATA_ADDR       = log2c(DATA_BANK_DEPTH),
   parameter int unsigned DATA_WE         = DATA_WIDTH_DATA / 8,
   parameter int unsigned CNT_WIDTH       = log2c(DATA_BANKS * DATA_BANK_DEPTH) + 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic [DATA_WIDTH_DATA-1:0]            s_axis_tdata,
   input  logic                                  s_axis_tvalid,
   output logic                                  s_axis_tready,
   input  logic                                  s_axis_tlast,
   output logic [DATA_BANKS-1:0]                 mb_bram_en,
   output logic [DATA_BANKS*DATA_WE-1:0]         mb_bram_we,
   output logic [DATA_BANKS*DATA_ADDR-1:0]       mb_bram_addr,
   output logic [DATA_BANKS*DATA_WIDTH_DATA-1:0] mb_bram_wrdata,
   output logic [CNT_WIDTH-1:0]                  load_count,
   output logic                                  load_done,
   output logic                                  data_ready,
   output logic                                  overflow
);

   localparam int unsigned BANK_W = log2c(DATA_BANKS);

   state_t              state, state_nxt;
   logic                beat, wr, accept_start, full;
   logic [BANK_W-1:0]   bank_idx;
   logic [DATA_ADDR-1:0] addr;

   assign s_axis_tready = (state == ST_LOAD);
   assign load_done     = (state == ST_DONE);
   assign accept_start  = (state == ST_IDLE) && start;
   assign beat          = s_axis_tvalid && s_axis_tready;
   assign wr            = beat && !full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_LOAD;
         ST_LOAD: if (beat && s_axis_tlast) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   bank_addr_counter #(
      .BANKS  (DATA_BANKS),
      .DEPTH  (DATA_BANK_DEPTH),
      .ADDR_W (DATA_ADDR),
      .BANK_W (BANK_W),
      .CNT_W  (CNT_WIDTH)
   ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (accept_start),
      .inc      (wr),
      .bank_idx (bank_idx),
      .addr     (addr),
      .count    (load_count),
      .full     (full)
   );

   // Enables pulse for one cycle per write; address slices of idle banks hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mb_bram_en     <= '0;
         mb_bram_we     <= '0;
         mb_bram_addr   <= '0;
         mb_bram_wrdata <= '0;
         overflow       <= 1'b0;
         data_ready     <= 1'b0;
      end else begin
         mb_bram_en <= '0;
         mb_bram_we <= '0;
         if (wr) begin
            for (int unsigned b = 0; b < DATA_BANKS; b++) begin
               if (bank_idx == BANK_W'(b)) begin
                  mb_bram_en[b]                             <= 1'b1;
                  mb_bram_we[b*DATA_WE +: DATA_WE]          <= '1;
                  mb_bram_addr[b*DATA_ADDR +: DATA_ADDR]    <= addr;
               end
            end
            mb_bram_wrdata <= {DATA_BANKS{s_axis_tdata}};
         end
         if (accept_start) begin
            overflow   <= 1'b0;
            data_ready <= 1'b0;
         end else begin
            if (beat && full)       overflow   <= 1'b1;
            if (state == ST_DONE)   data_ready <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_data_bram_loader.sv
// Scoreboard bench: two loader instances (4x256 and 3x4), expected writes/status queued by stimulus.
module tb_data_bram_loader;

   localparam int B0 = 4, D0 = 256, A0 = 8, C0 = 11;
   localparam int B1 = 3, D1 = 4,   A1 = 2, C1 = 5;

   typedef struct {
      int          bank;
      int          addr;
      logic [15:0] data;
   } wr_t;

   typedef struct {
      int   cnt;
      logic ovf;
   } st_t;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic              start0, tvalid0, tlast0, tready0, done0, rdy0, ovf0;
   logic [15:0]       tdata0;
   logic [B0-1:0]     en0;
   logic [B0*2-1:0]   we0;
   logic [B0*A0-1:0]  addr0;
   logic [B0*16-1:0]  wd0;
   logic [C0-1:0]     cnt0;

   logic              start1, tvalid1, tlast1, tready1, done1, rdy1, ovf1;
   logic [15:0]       tdata1;
   logic [B1-1:0]     en1;
   logic [B1*2-1:0]   we1;
   logic [B1*A1-1:0]  addr1;
   logic [B1*16-1:0]  wd1;
   logic [C1-1:0]     cnt1;

   data_bram_loader #(.DATA_WIDTH_DATA(16), .DATA_BANKS(B0), .DATA_BANK_DEPTH(D0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start0), .s_axis_tdata(tdata0),
      .s_axis_tvalid(tvalid0), .s_axis_tready(tready0), .s_axis_tlast(tlast0),
      .mb_bram_en(en0), .mb_bram_we(we0), .mb_bram_addr(addr0), .mb_bram_wrdata(wd0),
      .load_count(cnt0), .load_done(done0), .data_ready(rdy0), .overflow(ovf0));

   data_bram_loader #(.DATA_WIDTH_DATA(16), .DATA_BANKS(B1), .DATA_BANK_DEPTH(D1)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(start1), .s_axis_tdata(tdata1),
      .s_axis_tvalid(tvalid1), .s_axis_tready(tready1), .s_axis_tlast(tlast1),
      .mb_bram_en(en1), .mb_bram_we(we1), .mb_bram_addr(addr1), .mb_bram_wrdata(wd1),
      .load_count(cnt1), .load_done(done1), .data_ready(rdy1), .overflow(ovf1));

   int  n_tests = 0, n_fail = 0;
   wr_t q0[$], q1[$];
   st_t s0[$], s1[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (en0 != '0) begin
            if (q0.size() == 0) chk("wr0_unexpected", 64'(en0), 64'd0);
            else begin
               wr_t e;
               logic [B0-1:0] one;
               e = q0.pop_front();
               one = 1;
               chk("wr0_en",   64'(en0), 64'(one << e.bank));
               chk("wr0_we",   64'(we0[e.bank*2 +: 2]), 64'd3);
               chk("wr0_addr", 64'(addr0[e.bank*A0 +: A0]), 64'(e.addr));
               chk("wr0_data", wd0, {B0{e.data}});
            end
         end
         if (we0 != '0 && en0 == '0) chk("we0_without_en", 64'(we0), 64'd0);
         if (done0) begin
            if (s0.size() == 0) chk("done0_unexpected", 64'(done0), 64'd0);
            else begin
               st_t s;
               s = s0.pop_front();
               chk("count0", 64'(cnt0), 64'(s.cnt));
               chk("ovf0",   64'(ovf0), 64'(s.ovf));
               chk("tready0_in_done", 64'(tready0), 64'd0);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (en1 != '0) begin
            if (q1.size() == 0) chk("wr1_unexpected", 64'(en1), 64'd0);
            else begin
               wr_t e;
               logic [B1-1:0] one;
               e = q1.pop_front();
               one = 1;
               chk("wr1_en",   64'(en1), 64'(one << e.bank));
               chk("wr1_we",   64'(we1[e.bank*2 +: 2]), 64'd3);
               chk("wr1_addr", 64'(addr1[e.bank*A1 +: A1]), 64'(e.addr));
               chk("wr1_data", 64'(wd1), 64'({B1{e.data}}));
            end
         end
         if (done1) begin
            if (s1.size() == 0) chk("done1_unexpected", 64'(done1), 64'd0);
            else begin
               st_t s;
               s = s1.pop_front();
               chk("count1", 64'(cnt1), 64'(s.cnt));
               chk("ovf1",   64'(ovf1), 64'(s.ovf));
            end
         end
      end
   end

   task automatic drv(input int which, input logic v, input logic [15:0] d, input logic l);
      if (which == 0) begin tvalid0 = v; tdata0 = d; tlast0 = l; end
      else            begin tvalid1 = v; tdata1 = d; tlast1 = l; end
   endtask

   task automatic set_start(input int which, input logic v);
      if (which == 0) start0 = v; else start1 = v;
   endtask

   // Drives one block; start_mid also pulses start in LOAD and in DONE.
   task automatic run_block(input int which, input int n, input int base,
                            input bit gaps, input bit start_mid);
      int  nb  = (which == 0) ? B0 : B1;
      int  cap = (which == 0) ? B0 * D0 : B1 * D1;
      st_t s;
      set_start(which, 1'b1);
      @(negedge clk);
      set_start(which, 1'b0);
      chk("tready_load", 64'(which == 0 ? tready0 : tready1), 64'd1);
      chk("count_clr",   64'(which == 0 ? cnt0 : cnt1), 64'd0);
      chk("ready_clr",   64'(which == 0 ? rdy0 : rdy1), 64'd0);
      chk("ovf_clr",     64'(which == 0 ? ovf0 : ovf1), 64'd0);
      s.cnt = (n < cap) ? n : cap;
      s.ovf = (n > cap);
      if (which == 0) s0.push_back(s); else s1.push_back(s);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               drv(which, 1'b0, 16'hdead, 1'b0);
               @(negedge clk);
            end
         end
         if (i < cap) begin
            wr_t e;
            e.bank = i % nb;
            e.addr = i / nb;
            e.data = 16'(base + i);
            if (which == 0) q0.push_back(e); else q1.push_back(e);
         end
         drv(which, 1'b1, 16'(base + i), (i == n - 1));
         if (start_mid && i == 1) set_start(which, 1'b1);
         @(negedge clk);
         set_start(which, 1'b0);
      end
      drv(which, 1'b0, 16'h0, 1'b0);
      if (start_mid) set_start(which, 1'b1);
      @(negedge clk);
      set_start(which, 1'b0);
      chk("tready_idle", 64'(which == 0 ? tready0 : tready1), 64'd0);
      chk("data_ready",  64'(which == 0 ? rdy0 : rdy1), 64'd1);
      repeat (2) @(negedge clk);
      chk("stay_idle",   64'(which == 0 ? tready0 : tready1), 64'd0);
      chk("wr_pending",  64'(which == 0 ? q0.size() : q1.size()), 64'd0);
      chk("done_pending", 64'(which == 0 ? s0.size() : s1.size()), 64'd0);
   endtask

   initial begin
      start0 = 0; start1 = 0;
      drv(0, 1'b0, 16'h0, 1'b0);
      drv(1, 1'b0, 16'h0, 1'b0);
      repeat (3) @(negedge clk);
      chk("rst_en",    64'(en0), 64'd0);
      chk("rst_we",    64'(we0), 64'd0);
      chk("rst_addr",  64'(addr0), 64'd0);
      chk("rst_wd",    wd0, 64'd0);
      chk("rst_cnt",   64'(cnt0), 64'd0);
      chk("rst_flags", {60'd0, tready0, done0, rdy0, ovf0}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_block(0, 8, 1, 1'b0, 1'b0);
      run_block(0, 6, 16'h100, 1'b0, 1'b1);
      run_block(0, 100, 16'h2000, 1'b1, 1'b0);
      run_block(0, 1, 16'hbeef, 1'b0, 1'b0);
      run_block(1, 12, 16'h30, 1'b0, 1'b0);
      run_block(1, 15, 16'h40, 1'b0, 1'b0);
      run_block(1, 5, 16'h50, 1'b0, 1'b0);

      set_start(0, 1'b1);
      @(negedge clk);
      set_start(0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         wr_t e;
         e.bank = i; e.addr = 0; e.data = 16'(16'h70 + i);
         q0.push_back(e);
         drv(0, 1'b1, 16'(16'h70 + i), 1'b0);
         @(negedge clk);
      end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rstmid_en",    64'(en0), 64'd0);
      chk("rstmid_we",    64'(we0), 64'd0);
      chk("rstmid_flags", {60'd0, tready0, done0, rdy0, ovf0}, 64'd0);
      chk("rstmid_cnt",   64'(cnt0), 64'd0);
      chk("rstmid_rdy1",  64'(rdy1), 64'd0);
      q0.delete();
      drv(0, 1'b0, 16'h0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", 64'(tready0), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
